ddr_cas_data_burst: RTL and testbench

Target-side CAS responder for the DDR4 command path: accepts CAS commands from the CAS scheduler (`cas_rdy`/`cas_rw`), holds each one for its read (CL) or write (CWL) latency, then drives the data-burst window and pulses `rw_done` when the burst ends. It closes the loop for the scheduler's read/write turnaround logic. It supports multiple outstanding commands in strict issue order.

---
 rtl/ddr_cas_data_burst_if.sv | 46 ++++
 rtl/ddr_cas_data_burst.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddr_cas_data_burst.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cas_data_burst_if.sv
// ddr_cas_data_burst_if
// Bundles the CAS command inputs from the scheduler and the burst/status
// outputs of the CAS responder.
//   LAT_W      : width of the CL/CWL latency fields
//   cas_rdy    : single-cycle CAS issue strobe
//   cas_rw     : command type, READ=2'b01, WRITE=2'b10, other values invalid
//   CL / CWL   : read / write latency in clock cycles
//   BL         : burst length (8 or 4)
//   data_valid : high on each data beat
//   data_rw    : type of the active burst, 2'b00 when idle
//   beat_idx   : beat number within the burst
//   rw_done    : one-cycle pulse after a burst's last beat
//   busy       : queue non-empty or burst active
//   q_count    : queued commands, excluding the active burst
//   overflow   : sticky, CAS dropped on a full queue
//   timing_err : sticky, command matured while a burst was still running
// master = scheduler side, slave = responder side.
interface ddr_cas_data_burst_if #(
    parameter int unsigned LAT_W = 6
);
    logic             cas_rdy;
    logic [1:0]       cas_rw;
    logic [LAT_W-1:0] CL;
    logic [LAT_W-1:0] CWL;
    logic [3:0]       BL;
    logic             data_valid;
    logic [1:0]       data_rw;
    logic [1:0]       beat_idx;
    logic             rw_done;
    logic             busy;
    logic [3:0]       q_count;
    logic             overflow;
    logic             timing_err;

    modport master (
        output cas_rdy, cas_rw, CL, CWL, BL,
        input  data_valid, data_rw, beat_idx, rw_done,
        input  busy, q_count, overflow, timing_err
    );

    modport slave (
        input  cas_rdy, cas_rw, CL, CWL, BL,
        output data_valid, data_rw, beat_idx, rw_done,
        output busy, q_count, overflow, timing_err
    );
endinterface

// File: rtl/ddr_cas_data_burst.sv
// ddr_cas_data_burst
// Target-side CAS responder. Each accepted CAS command is queued with a
// countdown of its read (CL) or write (CWL) latency; when the head entry
// matures the burst engine drives the data-burst window and pulses rw_done
// after the last beat. Commands are served strictly in issue order.
//
// Optional feature macro: BURST_CHOP_EN
//   defined   : BL input of 4 gives a 2-beat burst, anything else 4 beats
//   undefined : BL is ignored, every burst is 4 beats
//
// Parameters
//   DEPTH : maximum outstanding queued commands (2..8)
//   LAT_W : width of CL/CWL and of the per-entry countdown
// Ports
//   clock_t : main clock, rising edge
//   reset   : synchronous active-high reset
//   bus     : ddr_cas_data_burst_if.slave (command inputs, burst/status outputs)
module ddr_cas_data_burst #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT_W = 6
) (
    input  logic                clock_t,
    input  logic                reset,
    ddr_cas_data_burst_if.slave bus
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BEAT_W = 2;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    // One queued CAS command; last_beat is the beat index that ends its burst.
    typedef struct packed {
        logic [1:0]        rw;
        logic [LAT_W-1:0]  cd;
        logic [BEAT_W-1:0] last_beat;
    } entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // Queue storage
    entry_t            fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Burst engine state and registered outputs
    state_t            state_q;
    state_t            state_d;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic [BEAT_W-1:0] cur_last_q;
    logic [BEAT_W-1:0] cur_last_d;
    logic [1:0]        data_rw_q;
    logic [1:0]        data_rw_d;
    logic              data_valid_q;
    logic              data_valid_d;
    logic              rw_done_q;
    logic              rw_done_d;
    logic              busy_q;
    logic [CNT_W-1:0]  q_count_q;
    logic              overflow_q;
    logic              timing_err_q;

    // Combinational helpers
    entry_t            head_c;
    entry_t            push_entry_c;
    logic              q_nonempty_c;
    logic              q_full_c;
    logic              head_ready_c;
    logic              head_matured_c;
    logic              last_beat_c;
    logic              engine_free_c;
    logic              pop_c;
    logic              stall_c;
    logic              cmd_valid_c;
    logic              push_c;
    logic              drop_c;
    logic [LAT_W-1:0]  lat_sel_c;
    logic [LAT_W-1:0]  lat_c;
    logic [BEAT_W-1:0] push_last_c;

    // Wrap-around pointer increment, DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Burst length selection for a newly pushed command.
`ifdef BURST_CHOP_EN
    assign push_last_c = (bus.BL == 4'd4) ? BEAT_W'(1) : BEAT_W'(3);
`else
    logic [3:0] bl_unused;
    assign bl_unused   = bus.BL;
    assign push_last_c = BEAT_W'(3);
`endif

    // Latency of the incoming command, clamped so the queue always has a cycle to register it.
    assign lat_sel_c = (bus.cas_rw == RW_READ) ? bus.CL : bus.CWL;
    assign lat_c     = (lat_sel_c < LAT_W'(2)) ? LAT_W'(2) : lat_sel_c;

    assign push_entry_c.rw        = bus.cas_rw;
    assign push_entry_c.cd        = lat_c - LAT_W'(1);
    assign push_entry_c.last_beat = push_last_c;

    // Head status. cd==1 means the countdown reaches 0 at this edge, so popping
    // now puts the first beat exactly lat cycles after issue.
    assign head_c         = fifo_q[rd_ptr_q];
    assign q_nonempty_c   = (count_q != '0);
    assign q_full_c       = (count_q == CNT_W'(DEPTH));
    assign head_ready_c   = q_nonempty_c && (head_c.cd <= LAT_W'(1));
    assign head_matured_c = q_nonempty_c && (head_c.cd == '0);

    assign last_beat_c    = (state_q == S_BURST) && (beat_q == cur_last_q);
    assign engine_free_c  = (state_q == S_IDLE) || last_beat_c;
    assign pop_c          = head_ready_c && engine_free_c;
    // A matured head that cannot start this cycle is already late.
    assign stall_c        = head_matured_c && !engine_free_c;

    assign cmd_valid_c    = bus.cas_rdy && ((bus.cas_rw == RW_READ) || (bus.cas_rw == RW_WRITE));
    assign push_c         = cmd_valid_c && (!q_full_c || pop_c);
    assign drop_c         = cmd_valid_c && q_full_c && !pop_c;

    // Command queue: circular buffer with free-running per-entry countdowns.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (fifo_q[i].cd != '0) begin
                    fifo_q[i].cd <= fifo_q[i].cd - LAT_W'(1);
                end
            end
            if (push_c) begin
                fifo_q[wr_ptr_q] <= push_entry_c;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Burst engine next-state and output decode.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cur_last_d = cur_last_q;
        data_rw_d  = data_rw_q;
        rw_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    state_d    = S_BURST;
                    beat_d     = '0;
                    cur_last_d = head_c.last_beat;
                    data_rw_d  = head_c.rw;
                end
            end
            S_BURST: begin
                if (last_beat_c) begin
                    rw_done_d = 1'b1;
                    if (pop_c) begin
                        // Back-to-back: next burst starts with no gap.
                        beat_d     = '0;
                        cur_last_d = head_c.last_beat;
                        data_rw_d  = head_c.rw;
                    end else begin
                        state_d   = S_IDLE;
                        beat_d    = '0;
                        data_rw_d = RW_IDLE;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                beat_d    = '0;
                data_rw_d = RW_IDLE;
            end
        endcase

        data_valid_d = (state_d == S_BURST);
    end

    // State register and registered outputs. busy/q_count lag the engine by one
    // cycle so busy covers the rw_done cycle.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            cur_last_q   <= '0;
            data_rw_q    <= RW_IDLE;
            data_valid_q <= 1'b0;
            rw_done_q    <= 1'b0;
            busy_q       <= 1'b0;
            q_count_q    <= '0;
            overflow_q   <= 1'b0;
            timing_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cur_last_q   <= cur_last_d;
            data_rw_q    <= data_rw_d;
            data_valid_q <= data_valid_d;
            rw_done_q    <= rw_done_d;
            busy_q       <= (state_q == S_BURST) || q_nonempty_c;
            q_count_q    <= count_q;
            overflow_q   <= overflow_q | drop_c;
            timing_err_q <= timing_err_q | stall_c;
        end
    end

    assign bus.data_valid = data_valid_q;
    assign bus.data_rw    = data_rw_q;
    assign bus.beat_idx   = beat_q;
    assign bus.rw_done    = rw_done_q;
    assign bus.busy       = busy_q;
    assign bus.q_count    = q_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.timing_err = timing_err_q;

endmodule

// File: tb/tb_ddr_cas_data_burst.sv
// tb_ddr_cas_data_burst
// Directed bench for ddr_cas_data_burst. Cycle 0 of each scenario is the first
// cycle after reset is released; inputs set in cycle c are sampled by the edge
// that starts cycle c+1; outputs are observed 1 time unit after that edge.
module tb_ddr_cas_data_burst;

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

`ifdef BURST_CHOP_EN
    localparam int CHOP_LAST_DV = 10;
`else
    localparam int CHOP_LAST_DV = 12;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    ddr_cas_data_burst_if #(.LAT_W(6)) bus ();

    ddr_cas_data_burst #(
        .DEPTH (4),
        .LAT_W (6)
    ) dut (
        .clock_t (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus.cas_rdy = 1'b0;
        bus.cas_rw  = 2'b00;
        bus.CL      = 6'd11;
        bus.CWL     = 6'd9;
        bus.BL      = 4'd8;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 8;
        if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset data_valid: got %b want 0", bus.data_valid); end
        if (bus.data_rw !== 2'b00) begin miscompares++; $display("FAIL reset data_rw: got %b want 00", bus.data_rw); end
        if (bus.beat_idx !== 2'b00) begin miscompares++; $display("FAIL reset beat_idx: got %b want 00", bus.beat_idx); end
        if (bus.rw_done !== 1'b0) begin miscompares++; $display("FAIL reset rw_done: got %b want 0", bus.rw_done); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        if (bus.q_count !== 4'd0) begin miscompares++; $display("FAIL reset q_count: got %0d want 0", bus.q_count); end
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset overflow: got %b want 0", bus.overflow); end
        if (bus.timing_err !== 1'b0) begin miscompares++; $display("FAIL reset timing_err: got %b want 0", bus.timing_err); end
    endtask

    task automatic test_single_read();
        logic       exp_dv;
        logic [1:0] exp_rw;
        logic       exp_done;
        logic       exp_busy;
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            exp_dv   = (c >= 11 && c <= 14);
            exp_rw   = exp_dv ? RD : 2'b00;
            exp_done = (c == 15);
            exp_busy = (c >= 2 && c <= 15);
            vectors += 4;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL single dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.data_rw !== exp_rw) begin miscompares++; $display("FAIL single data_rw cyc %0d: got %b want %b", c, bus.data_rw, exp_rw); end
            if (bus.rw_done !== exp_done) begin miscompares++; $display("FAIL single rw_done cyc %0d: got %b want %b", c, bus.rw_done, exp_done); end
            if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL single busy cyc %0d: got %b want %b", c, bus.busy, exp_busy); end
            if (exp_dv) begin
                vectors++;
                if (bus.beat_idx !== 2'(c - 11)) begin miscompares++; $display("FAIL single beat cyc %0d: got %0d want %0d", c, bus.beat_idx, c - 11); end
            end
            if (c == 2 || c == 12) begin
                vectors++;
                if (bus.q_count !== ((c == 2) ? 4'd1 : 4'd0)) begin miscompares++; $display("FAIL single q_count cyc %0d: got %0d", c, bus.q_count); end
            end
            bus.cas_rdy = (c == 0);
            bus.cas_rw  = RD;
            step();
        end
    endtask

    task automatic test_min_latency();
        logic exp_dv;
        do_reset();
        bus.CL = 6'd0;
        for (int c = 0; c <= 8; c++) begin
            exp_dv = (c >= 2 && c <= 5);
            vectors += 2;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL minlat dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.rw_done !== (c == 6)) begin miscompares++; $display("FAIL minlat rw_done cyc %0d: got %b want %b", c, bus.rw_done, c == 6); end
            bus.cas_rdy = (c == 0);
            bus.cas_rw  = RD;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic exp_dv;
        logic exp_done;
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            exp_dv   = (c >= 11 && c <= 18);
            exp_done = (c == 15 || c == 19);
            vectors += 4;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL b2b dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.rw_done !== exp_done) begin miscompares++; $display("FAIL b2b rw_done cyc %0d: got %b want %b", c, bus.rw_done, exp_done); end
            if (bus.timing_err !== 1'b0) begin miscompares++; $display("FAIL b2b timing_err cyc %0d: got %b want 0", c, bus.timing_err); end
            if (bus.data_rw !== (exp_dv ? RD : 2'b00)) begin miscompares++; $display("FAIL b2b data_rw cyc %0d: got %b", c, bus.data_rw); end
            if (exp_dv) begin
                vectors++;
                if (bus.beat_idx !== 2'(c - 11)) begin miscompares++; $display("FAIL b2b beat cyc %0d: got %0d want %0d", c, bus.beat_idx, (c - 11) % 4); end
            end
            bus.cas_rdy = (c == 0 || c == 4);
            bus.cas_rw  = RD;
            step();
        end
    endtask

    task automatic test_stall();
        logic exp_dv;
        logic exp_done;
        logic exp_err;
        do_reset();
        for (int c = 0; c <= 21; c++) begin
            exp_dv   = (c >= 11 && c <= 18);
            exp_done = (c == 15 || c == 19);
            exp_err  = (c >= 14);
            vectors += 3;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL stall dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.rw_done !== exp_done) begin miscompares++; $display("FAIL stall rw_done cyc %0d: got %b want %b", c, bus.rw_done, exp_done); end
            if (bus.timing_err !== exp_err) begin miscompares++; $display("FAIL stall timing_err cyc %0d: got %b want %b", c, bus.timing_err, exp_err); end
            if (exp_dv) begin
                vectors++;
                if (bus.beat_idx !== 2'(c - 11)) begin miscompares++; $display("FAIL stall beat cyc %0d: got %0d want %0d", c, bus.beat_idx, (c - 11) % 4); end
            end
            bus.cas_rdy = (c == 0 || c == 2);
            bus.cas_rw  = RD;
            step();
        end
    endtask

    task automatic test_overflow();
        logic exp_dv;
        logic exp_done;
        int   dv_seen;
        int   done_seen;
        dv_seen   = 0;
        done_seen = 0;
        do_reset();
        bus.CL = 6'd30;
        for (int c = 0; c <= 50; c++) begin
            exp_dv   = (c >= 30 && c <= 45);
            exp_done = (c == 34 || c == 38 || c == 42 || c == 46);
            if (bus.data_valid === 1'b1) dv_seen++;
            if (bus.rw_done === 1'b1) done_seen++;
            vectors += 3;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL ovf dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.rw_done !== exp_done) begin miscompares++; $display("FAIL ovf rw_done cyc %0d: got %b want %b", c, bus.rw_done, exp_done); end
            if (bus.overflow !== (c >= 17)) begin miscompares++; $display("FAIL ovf overflow cyc %0d: got %b want %b", c, bus.overflow, c >= 17); end
            if (c == 14) begin
                vectors++;
                if (bus.q_count !== 4'd4) begin miscompares++; $display("FAIL ovf q_count cyc 14: got %0d want 4", bus.q_count); end
            end
            bus.cas_rdy = (c <= 16) && (c % 4 == 0);
            bus.cas_rw  = RD;
            step();
        end
        vectors += 2;
        if (done_seen !== 4) begin miscompares++; $display("FAIL ovf done_pulses: got %0d want 4", done_seen); end
        if (dv_seen !== 16) begin miscompares++; $display("FAIL ovf beats: got %0d want 16", dv_seen); end
    endtask

    task automatic test_full_pop_push();
        logic exp_dv;
        logic exp_done;
        int   done_seen;
        done_seen = 0;
        do_reset();
        for (int c = 0; c <= 36; c++) begin
            exp_dv   = (c >= 11 && c <= 30);
            exp_done = (c >= 15 && c <= 31 && ((c - 15) % 4 == 0));
            if (bus.rw_done === 1'b1) done_seen++;
            vectors += 3;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL fullpp dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.rw_done !== exp_done) begin miscompares++; $display("FAIL fullpp rw_done cyc %0d: got %b want %b", c, bus.rw_done, exp_done); end
            if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL fullpp overflow cyc %0d: got %b want 0", c, bus.overflow); end
            bus.cas_rdy = (c <= 3) || (c == 10);
            bus.cas_rw  = RD;
            step();
        end
        vectors++;
        if (done_seen !== 5) begin miscompares++; $display("FAIL fullpp done_pulses: got %0d want 5", done_seen); end
    endtask

    task automatic test_reset_abort();
        logic       exp_dv;
        logic [1:0] exp_rw;
        do_reset();
        for (int c = 0; c <= 35; c++) begin
            exp_dv = (c == 11 || c == 12 || (c >= 29 && c <= 32));
            exp_rw = exp_dv ? ((c < 20) ? RD : WR) : 2'b00;
            vectors += 3;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL rstab dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.data_rw !== exp_rw) begin miscompares++; $display("FAIL rstab data_rw cyc %0d: got %b want %b", c, bus.data_rw, exp_rw); end
            if (bus.rw_done !== (c == 33)) begin miscompares++; $display("FAIL rstab rw_done cyc %0d: got %b want %b", c, bus.rw_done, c == 33); end
            if (c == 13) begin
                vectors += 3;
                if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstab busy cyc 13: got %b want 0", bus.busy); end
                if (bus.q_count !== 4'd0) begin miscompares++; $display("FAIL rstab q_count cyc 13: got %0d want 0", bus.q_count); end
                if (bus.beat_idx !== 2'd0) begin miscompares++; $display("FAIL rstab beat cyc 13: got %0d want 0", bus.beat_idx); end
            end
            reset       = (c == 12);
            bus.cas_rdy = (c == 0 || c == 20);
            bus.cas_rw  = (c < 20) ? RD : WR;
            step();
        end
    endtask

    task automatic test_burst_len();
        logic exp_dv;
        do_reset();
        bus.BL = 4'd4;
        for (int c = 0; c <= 16; c++) begin
            exp_dv = (c >= 9 && c <= CHOP_LAST_DV);
            vectors += 2;
            if (bus.data_valid !== exp_dv) begin miscompares++; $display("FAIL bl dv cyc %0d: got %b want %b", c, bus.data_valid, exp_dv); end
            if (bus.rw_done !== (c == CHOP_LAST_DV + 1)) begin miscompares++; $display("FAIL bl rw_done cyc %0d: got %b want %b", c, bus.rw_done, c == CHOP_LAST_DV + 1); end
            bus.cas_rdy = (c == 0);
            bus.cas_rw  = WR;
            step();
        end
    endtask

    task automatic test_invalid();
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            vectors += 3;
            if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL invalid dv cyc %0d: got %b want 0", c, bus.data_valid); end
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL invalid busy cyc %0d: got %b want 0", c, bus.busy); end
            if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL invalid overflow cyc %0d: got %b want 0", c, bus.overflow); end
            bus.cas_rdy = (c <= 1);
            bus.cas_rw  = (c == 0) ? 2'b00 : 2'b11;
            step();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_read();
        test_min_latency();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_full_pop_push();
        test_reset_abort();
        test_burst_len();
        test_invalid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
